nixie_scan_controller: RTL and testbench

Time-multiplexed scan controller for a bank of common-anode seven-segment digits. It holds a CPU-writable 32-bit display value and a control word. It steps through the digits at a fixed slot rate and presents one 4-bit nibble per slot to `nixie_decoder`, whose active-low segment output drives the shared cathode lines. Display data is double-buffered so a new value only appears at a frame boundary, and a blanking interval at the start of each slot suppresses ghosting.

---
 rtl/nixie_scan_if.sv | 22 ++
 rtl/nixie_scan_controller.sv | 104 ++++++++++
 tb/tb_nixie_scan_controller.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/nixie_scan_if.sv
// Register bus between a CPU-side master and the nixie scan controller.
// One write per cycle; rdata is combinational from the addressed register.
interface nixie_scan_if;
    logic        we;
    logic        addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output we,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  we,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/nixie_scan_controller.sv
// Time-multiplexed seven-segment scan controller with a frame-synchronous
// display buffer, per-slot blanking, digit masking and leading-zero suppression.
module nixie_scan_controller #(
    parameter int DIGITS   = 8,
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    nixie_scan_if.slave       bus,
    output logic [3:0]        nibble,
    output logic [DIGITS-1:0] dig_sel,
    output logic              frame_tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] ONE_HOT0 = DIGITS'(1);

    logic [31:0]      pending;
    logic [31:0]      shown;
    logic             en;
    logic             lzs;
    logic [7:0]       mask;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;

    logic [DIGITS-1:0] nib_zero;
    logic [DIGITS-1:0] below_idx;
    logic [3:0]        cur_nib_p0;
    logic              suppress_p0;
    logic              lit_p0;
    logic              frame_end_p0;

    function automatic logic [3:0] shown_nibble(input logic [31:0] buf_val,
                                                input logic [IDX_W-1:0] sel);
        return buf_val[{sel, 2'b00} +: 4];
    endfunction

    always_comb begin
        nib_zero = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib_zero[i] = (shown[4*i +: 4] == 4'h0);
        end
    end

    // Digits below idx are forced "zero" so the AND reduces over idx..DIGITS-1 only.
    assign below_idx    = (ONE_HOT0 << idx) - ONE_HOT0;
    assign suppress_p0  = lzs && (idx != '0) && (&(nib_zero | below_idx));
    assign cur_nib_p0   = shown_nibble(shown, idx);
    assign lit_p0       = en && (cnt >= CNT_BLANK) && mask[idx] && !suppress_p0;
    assign frame_end_p0 = en && (cnt == CNT_LAST) && (idx == IDX_LAST);

    assign bus.rdata = bus.addr ? {16'h0000, mask, 6'b000000, lzs, en} : pending;

    // Stage p0 -> p1: scan state, register file and registered display outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            pending    <= '0;
            shown      <= '0;
            en         <= 1'b1;
            lzs        <= 1'b0;
            mask       <= 8'hFF;
            dig_sel    <= '1;
            nibble     <= 4'h0;
            frame_tick <= 1'b0;
        end else begin
            if (!en) begin
                cnt <= '0;
                idx <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // Old pending wins over a same-cycle DATA write at a frame boundary.
            if (!en || frame_end_p0) begin
                shown <= pending;
            end

            if (bus.we && !bus.addr) begin
                pending <= bus.wdata;
            end
            if (bus.we && bus.addr) begin
                en   <= bus.wdata[0];
                lzs  <= bus.wdata[1];
                mask <= bus.wdata[15:8];
            end

            dig_sel    <= lit_p0 ? ~(ONE_HOT0 << idx) : '1;
            nibble     <= lit_p0 ? cur_nib_p0 : 4'h0;
            frame_tick <= frame_end_p0;
        end
    end

endmodule

// File: tb/tb_nixie_scan_controller.sv
// Bench for nixie_scan_controller: per-cycle comparison against a position-based
// behavioural model plus hand-computed directed expectations.
module tb_nixie_scan_controller;

    localparam int D = 4;
    localparam int P = 8;
    localparam int B = 2;

    logic       clk;
    logic       rst_n;
    logic [3:0] nibble;
    logic [3:0] dig_sel;
    logic       frame_tick;

    nixie_scan_if bus_if ();

    nixie_scan_controller #(.DIGITS(D), .PRESCALE(P), .BLANK(B)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if),
        .nibble     (nibble),
        .dig_sel    (dig_sel),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: scan position counted in cycles since scanning (re)started.
    int          m_pos;
    logic [31:0] m_pend, m_shown, m_ctrl;
    logic [3:0]  e_dig, e_nib;
    logic        e_tick;
    bit          model_valid = 0;
    int          mc, mi;
    logic        m_en, m_lit;
    longint unsigned tl, tm;
    logic [31:0] sh;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pend = 0; m_shown = 0; m_ctrl = 32'h0000FF01; m_pos = 0;
            e_dig = 4'hF; e_nib = 0; e_tick = 0;
            model_valid = 1; cyc = 0;
        end else if (model_valid) begin
            mc   = m_pos % P;
            mi   = (m_pos / P) % D;
            m_en = m_ctrl[0];
            tl   = {32'h0, m_shown} >> (4 * mi);
            tm   = (64'd1 << (4 * (D - mi))) - 64'd1;
            sh   = m_shown >> (4 * mi);
            m_lit = m_en && (mc >= B) && m_ctrl[8 + mi] &&
                    !(m_ctrl[1] && (mi > 0) && ((tl & tm) == 0));
            e_dig  = m_lit ? ~(4'b0001 << mi) : 4'hF;
            e_nib  = m_lit ? sh[3:0] : 4'h0;
            e_tick = m_en && ((m_pos % (D * P)) == D * P - 1);
            if (!m_en || e_tick) m_shown = m_pend;
            m_pos = m_en ? m_pos + 1 : 0;
            if (bus_if.we) begin
                if (bus_if.addr) m_ctrl = bus_if.wdata & 32'h0000FF03;
                else             m_pend = bus_if.wdata;
            end
            cyc = cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            chk("model.dig_sel", {28'h0, dig_sel}, {28'h0, e_dig});
            chk("model.nibble", {28'h0, nibble}, {28'h0, e_nib});
            chk("model.frame_tick", {31'h0, frame_tick}, {31'h0, e_tick});
            chk("model.rdata", bus_if.rdata, bus_if.addr ? m_ctrl : m_pend);
        end
    end

    task automatic goto(input int n);
        int g;
        g = 0;
        while (cyc != n && g < 2000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (cyc != n) begin
            n_checks++;
            n_fail++;
            $display("FAIL goto: cycle %0d never reached (at %0d)", n, cyc);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_if.we = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic write_reg(input logic a, input logic [31:0] d);
        bus_if.we    = 1'b1;
        bus_if.addr  = a;
        bus_if.wdata = d;
        @(posedge clk);
        #1;
        bus_if.we   = 1'b0;
        bus_if.addr = 1'b0;
    endtask

    task automatic check_rd(input string name, input logic a, input logic [31:0] exp);
        bus_if.addr = a;
        #1;
        chk(name, bus_if.rdata, exp);
        bus_if.addr = 1'b0;
    endtask

    task automatic check_out(input string name, input logic [3:0] dig,
                             input logic [3:0] nib, input logic tick);
        #1;
        chk({name, ".dig"}, {28'h0, dig_sel}, {28'h0, dig});
        chk({name, ".nib"}, {28'h0, nibble}, {28'h0, nib});
        chk({name, ".tick"}, {31'h0, frame_tick}, {31'h0, tick});
    endtask

    task automatic check_reset_state(input string name);
        check_rd({name, ".ctrl"}, 1'b1, 32'h0000FF01);
        check_rd({name, ".data"}, 1'b0, 32'h0);
        check_out({name, ".c0"}, 4'hF, 4'h0, 1'b0);
        goto(1);  check_out({name, ".c1"}, 4'hF, 4'h0, 1'b0);
        goto(2);  check_out({name, ".c2"}, 4'hF, 4'h0, 1'b0);
        goto(3);  check_out({name, ".c3"}, 4'hE, 4'h0, 1'b0);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus_if.we    = 1'b0;
        bus_if.addr  = 1'b0;
        bus_if.wdata = 32'h0;

        // Reset values, slot timing and double buffering
        do_reset();
        check_reset_state("rst");
        goto(5);  write_reg(1'b0, 32'h00001234);
        check_rd("db.rd", 1'b0, 32'h00001234);
        goto(8);  check_out("rst.c8", 4'hE, 4'h0, 1'b0);
        goto(9);  check_out("rst.c9", 4'hF, 4'h0, 1'b0);
        goto(30); check_out("db.c30", 4'h7, 4'h0, 1'b0);
        goto(31); check_out("db.c31", 4'h7, 4'h0, 1'b0);
        goto(32); check_out("db.c32", 4'h7, 4'h0, 1'b1);
        goto(33); check_out("db.c33", 4'hF, 4'h0, 1'b0);
        goto(35); check_out("db.d0", 4'hE, 4'h4, 1'b0);
        goto(43); check_out("db.d1", 4'hD, 4'h3, 1'b0);
        goto(51); check_out("db.d2", 4'hB, 4'h2, 1'b0);
        goto(59); check_out("db.d3", 4'h7, 4'h1, 1'b0);

        // DATA write coinciding with the frame boundary
        do_reset();
        goto(31); write_reg(1'b0, 32'h0000ABCD);
        goto(35); check_out("wb.f2d0", 4'hE, 4'h0, 1'b0);
        goto(59); check_out("wb.f2d3", 4'h7, 4'h0, 1'b0);
        goto(67); check_out("wb.f3d0", 4'hE, 4'hD, 1'b0);
        goto(75); check_out("wb.f3d1", 4'hD, 4'hC, 1'b0);
        goto(83); check_out("wb.f3d2", 4'hB, 4'hB, 1'b0);
        goto(91); check_out("wb.f3d3", 4'h7, 4'hA, 1'b0);

        // Leading-zero suppression
        do_reset();
        write_reg(1'b1, 32'h0000FF03);
        write_reg(1'b0, 32'h00000050);
        goto(35); check_out("lzs.d0", 4'hE, 4'h0, 1'b0);
        goto(43); check_out("lzs.d1", 4'hD, 4'h5, 1'b0);
        goto(51); check_out("lzs.d2", 4'hF, 4'h0, 1'b0);
        goto(59); check_out("lzs.d3", 4'hF, 4'h0, 1'b0);
        goto(60); write_reg(1'b0, 32'h0);
        goto(67); check_out("lzs0.d0", 4'hE, 4'h0, 1'b0);
        goto(75); check_out("lzs0.d1", 4'hF, 4'h0, 1'b0);
        goto(91); check_out("lzs0.d3", 4'hF, 4'h0, 1'b0);

        // Mask, disable mid-slot, re-enable
        do_reset();
        write_reg(1'b1, 32'h00000501);
        write_reg(1'b0, 32'h00004321);
        goto(3);  check_out("msk.f1d0", 4'hE, 4'h0, 1'b0);
        goto(11); check_out("msk.f1d1", 4'hF, 4'h0, 1'b0);
        goto(19); check_out("msk.f1d2", 4'hB, 4'h0, 1'b0);
        goto(27); check_out("msk.f1d3", 4'hF, 4'h0, 1'b0);
        goto(35); check_out("msk.f2d0", 4'hE, 4'h1, 1'b0);
        goto(43); check_out("msk.f2d1", 4'hF, 4'h0, 1'b0);
        goto(51); check_out("msk.f2d2", 4'hB, 4'h3, 1'b0);
        goto(52); write_reg(1'b1, 32'h00000500);
        check_out("dis.c53", 4'hB, 4'h3, 1'b0);
        goto(54); check_out("dis.c54", 4'hF, 4'h0, 1'b0);
        goto(64); check_out("dis.notick", 4'hF, 4'h0, 1'b0);
        goto(70); write_reg(1'b1, 32'h00000501);
        goto(73); check_out("ren.c73", 4'hF, 4'h0, 1'b0);
        goto(74); check_out("ren.c74", 4'hE, 4'h1, 1'b0);
        goto(102); check_out("ren.c102", 4'hF, 4'h0, 1'b0);
        goto(103); check_out("ren.tick", 4'hF, 4'h0, 1'b1);

        // Reset asserted mid-frame
        do_reset();
        goto(2);  write_reg(1'b0, 32'h00005678);
        goto(3);  write_reg(1'b1, 32'h0000AA02);
        goto(6);  write_reg(1'b1, 32'h0000FF01);
        goto(10); check_out("mid.pre0", 4'hE, 4'h8, 1'b0);
        goto(20); check_out("mid.pre1", 4'hD, 4'h7, 1'b0);
        goto(25);
        do_reset();
        check_reset_state("mid");
        goto(31); check_out("mid.c31", 4'h7, 4'h0, 1'b0);
        goto(32); check_out("mid.c32", 4'h7, 4'h0, 1'b1);

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
